// File: rtl/dnn_neuron_mac.sv
// Streaming multiply-accumulate neuron.
// Accepts (x, w) pairs and accumulates their Q5.10 products. It then adds the
// bias, rounds half-up and saturates to DATA_W. Finally it applies ReLU or hard
// sigmoid and presents the result on a valid/ready port. One vector is in
// flight at a time.
module dnn_neuron_mac #(
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 10,
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 64
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_x,
  input  logic signed [DATA_W-1:0] s_w,
  input  logic                     s_last,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     act_sel,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_ovf,
  output logic                     busy
);

  localparam int CNT_W  = $clog2(MAX_TERMS + 1);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    ACC_W'(-(64'sd1 <<< (DATA_W - 1)));
  localparam logic signed [ACC_W-1:0] RND_HALF =
    ACC_W'(64'sd1 <<< (FRAC_W - 1));
  localparam logic signed [DATA_W:0] HS_OFF =
    (DATA_W + 1)'(64'sd1 <<< (FRAC_W - 1));
  localparam logic signed [DATA_W:0] HS_ONE =
    (DATA_W + 1)'(64'sd1 <<< FRAC_W);

  typedef enum logic [1:0] {
    ST_ACC,
    ST_DRAIN,
    ST_FIN,
    ST_OUT
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]         cnt;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] bias_r;
  logic                     act_r;

  logic                     hs;
  logic                     last_hs;
  logic                     out_take;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_sh;
  logic signed [ACC_W-1:0]  sum_fin;
  logic signed [ACC_W-1:0]  y_wide;
  logic [DATA_W:0]          sat_res;
  logic signed [DATA_W-1:0] act_res;

  // Saturate a wide value to DATA_W; the top bit of the result flags clipping.
  function automatic logic [DATA_W:0] sat_round(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return {1'b1, SAT_MAX[DATA_W-1:0]};
    end else if (v < SAT_MIN) begin
      return {1'b1, SAT_MIN[DATA_W-1:0]};
    end else begin
      return {1'b0, v[DATA_W-1:0]};
    end
  endfunction

  // ReLU (sel = 0) or hard sigmoid clamp((y >>> 2) + 0.5, 0, 1.0) (sel = 1).
  function automatic logic signed [DATA_W-1:0] activate(
    input logic signed [DATA_W-1:0] y,
    input logic                     sel
  );
    logic signed [DATA_W:0] hs_v;
    hs_v = ($signed({y[DATA_W-1], y}) >>> 2) + HS_OFF;
    if (!sel) begin
      return y[DATA_W-1] ? '0 : y;
    end else if (hs_v[DATA_W]) begin
      return '0;
    end else if (hs_v > HS_ONE) begin
      return HS_ONE[DATA_W-1:0];
    end else begin
      return hs_v[DATA_W-1:0];
    end
  endfunction

  assign hs       = s_valid & (state == ST_ACC);
  assign last_hs  = hs & (s_last | (cnt == CNT_W'(MAX_TERMS - 1)));
  assign out_take = (state == ST_OUT) & m_ready;

  assign s_ready = (state == ST_ACC);
  assign m_valid = (state == ST_OUT);
  assign busy    = (state != ST_ACC) | (cnt != '0);

  assign prod_ext = {{(ACC_W - PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
  assign bias_sh  = {{(ACC_W - DATA_W){bias_r[DATA_W-1]}}, bias_r} <<< FRAC_W;
  assign sum_fin  = acc + bias_sh + RND_HALF;
  assign y_wide   = sum_fin >>> FRAC_W;
  assign sat_res  = sat_round(y_wide);
  assign act_res  = activate(sat_res[DATA_W-1:0], act_r);

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_ACC;
    else          state <= state_nxt;
  end

  // Next-state logic: accumulate, drain the product register, finish, present.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:   if (last_hs) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_OUT;
      ST_OUT:   if (m_ready) state_nxt = ST_ACC;
      default:  state_nxt = ST_ACC;
    endcase
  end

  // Stage p1: register the product of each accepted pair.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= hs;
      if (hs) prod_p1 <= s_x * s_w;
    end
  end

  // Stage p2: accumulate; term count and per-vector bias/activation capture.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc    <= '0;
      cnt    <= '0;
      bias_r <= '0;
      act_r  <= 1'b0;
    end else begin
      if (out_take) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        if (vld_p1) acc <= acc + prod_ext;
        if (hs)     cnt <= cnt + 1'b1;
      end
      if (hs && cnt == '0) begin
        bias_r <= bias;
        act_r  <= act_sel;
      end
    end
  end

  // Stage p3: bias, round, saturate, activate; result held until the next FIN.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_data <= '0;
      m_ovf  <= 1'b0;
    end else if (state == ST_FIN) begin
      m_data <= act_res;
      m_ovf  <= sat_res[DATA_W];
    end
  end

endmodule

// File: doc/dnn_neuron_mac.md
# dnn_neuron_mac

Streaming multiply-accumulate neuron for the AXI DNN accelerator. It receives (input, weight) pairs from the layer sequencer, which reads them from the register-file weight/input banks, and accumulates their products in Q5.10 fixed point (1024 = 1.0). It then adds the bias, rounds, saturates and applies the selected activation. The result is handed downstream to the layer-output bank through a valid/ready port.

## Interface
- DATA_W, 16, signed operand/result width
- FRAC_W, 10, fractional bits (Q5.10)
- ACC_W, 40, accumulator width
- MAX_TERMS, 64, maximum pairs per dot product
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- s_valid  in  1  input pair valid
- s_ready  out  1  block accepts pair
- s_x  in  DATA_W  signed input activation
- s_w  in  DATA_W  signed weight
- s_last  in  1  final pair of this dot product
- bias  in  DATA_W  signed Q5.10 bias, captured on first accepted pair
- act_sel  in  1  0 = ReLU, 1 = hard sigmoid; captured on first accepted pair
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  DATA_W  activated Q5.10 result
- m_ovf  out  1  pre-activation value saturated; valid with m_valid
- busy  out  1  vector in progress (any pair accepted, result not yet taken)

## Operation
- States: ACC, DRAIN, FIN, OUT. Reset → ACC with accumulator = 0, term count = 0.
- ACC: s_ready = 1. Handshake = s_valid & s_ready.
  - Each handshake registers prod_r = s_x * s_w (2·DATA_W signed) and prod_vld.
  - Each handshake increments the term count.
  - The first handshake of a vector also captures bias and act_sel.
  - When prod_vld is set, prod_r is sign-extended to ACC_W and added to the accumulator.
  - On a handshake with s_last = 1, or on the MAX_TERMS-th handshake (forced last), go to DRAIN.
- DRAIN: s_ready = 0; the final prod_r is added. Go to FIN.
- FIN:
  - sum = acc + (sign-extended bias <<< FRAC_W) + 2^(FRAC_W-1).
  - y = sum >>> FRAC_W, saturated to [-32768, 32767]. m_ovf = 1 if clipping occurred.
  - ReLU: out = max(0, y).
  - Hard sigmoid: out = clamp((y >>> 2) + 512, 0, 1024).
  - Register out into m_data and go to OUT.
- OUT: m_valid = 1; m_data and m_ovf are held stable. On m_ready, clear the accumulator, count and m_valid, then go to ACC.
- s_ready is 0 in DRAIN, FIN and OUT. There is no overlap between vectors.
- Arithmetic right shifts floor, so rounding is half-up toward +∞.

## Timing
- Reset values: s_ready = 1, m_valid = 0, m_data = 0, m_ovf = 0, busy = 0.
- Throughput: one pair per cycle in ACC.
- Latency: with the last handshake at edge k, m_valid rises after edge k+3 (DRAIN at k+1, FIN at k+2, OUT at k+3).
- With m_ready held high, the next vector's first pair can be accepted on the cycle after the m_valid/m_ready handshake.
- Back-to-back: the cycle after the m_ready handshake has s_ready = 1.
- m_valid, once high, stays high until m_ready. m_data must not change while m_valid is high.
- s_last on the forced MAX_TERMS-th pair: same behaviour as a forced last, with no double completion.
- aresetn low at any time, including mid-accumulation or in OUT:
  - immediately (asynchronously) returns to the reset state;
  - drops m_valid;
  - discards the partial sum.
  - The first vector after release must not contain residue.

## Test plan
- Single pair: x = 1024, w = 1024, bias = 0, ReLU → m_data = 1024, m_ovf = 0, m_valid 3 cycles after the last handshake.
- Two pairs: (512, 410), (410, 205), bias = 0, ReLU → m_data = 287. Then the same pairs with bias = 1024 → 1311.
- Negative result: x = -1024, w = 1024, bias = 0.
  - ReLU → 0.
  - Hard sigmoid → 256.
  - x = 4096, w = 1024, hard sigmoid → 1024 (clamp).
- Saturation: four pairs (32767, 32767), ReLU → m_data = 32767, m_ovf = 1. The same input with hard sigmoid → 1024, m_ovf = 1.
- Length and backpressure:
  - 64 pairs of (1024, 16) with s_last never asserted → forced completion; m_data = 1024.
  - Hold m_ready low 5 cycles: m_valid and m_data stable, s_ready = 0.
  - Next vector accepted right after the handshake.
- Reset mid-operation: assert aresetn low after 3 of 5 pairs, release, then send single pair (512, 512) → m_data = 256. All outputs take reset values while reset is low.
